// File: rtl/rescale_scheduler.sv
// Frame sequencer for the bilinear rescaler: walks destination pixels in raster order,
// fetches each 2x2 source neighbourhood and emits the four bilinear weights per pixel.
module rescale_scheduler #(
  parameter int DIM_W = 10,
  parameter int FRAC  = 5,
  parameter int WL    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] src_w,
  input  logic [DIM_W-1:0] src_h,
  input  logic [DIM_W-1:0] dst_w,
  input  logic [DIM_W-1:0] dst_h,
  input  logic [WL-1:0]    scale_c,
  input  logic [WL-1:0]    scale_r,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             rd_req,
  output logic [DIM_W-1:0] rd_row,
  output logic [DIM_W-1:0] rd_col,
  input  logic             rd_ack,
  output logic [WL-1:0]    m3,
  output logic [WL-1:0]    m4,
  output logic [WL-1:0]    m5,
  output logic [WL-1:0]    m6,
  output logic             calc_valid,
  input  logic             out_ready,
  output logic [DIM_W-1:0] dst_row,
  output logic [DIM_W-1:0] dst_col
);

  localparam int AW = DIM_W + FRAC + 1;  // accumulator width
  localparam int IW = DIM_W + 1;         // integer part of an accumulator
  localparam int DW = FRAC + 1;          // delta width, range 0..1.0
  localparam int PW = 2 * DW;            // weight product width
  localparam logic [DW-1:0] ONE = DW'(1 << FRAC);

  typedef enum logic [2:0] {IDLE, ADDR, FETCH, WEIGHT, EMIT, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc_r, acc_c;
  logic [DW-1:0] dr, dc;
  logic          err_q;

  logic [IW-1:0] int_r, int_c;
  logic          clamp_r, clamp_c;
  logic          cfg_bad;
  logic [DW-1:0] inv_r, inv_c;
  logic [PW-1:0] p3, p4, p5, p6;

  assign int_r = acc_r[AW-1:FRAC];
  assign int_c = acc_c[AW-1:FRAC];

  // At or past the last source line the neighbourhood is pinned to the final pair
  // with a full 1.0 delta, so the far neighbour carries the whole weight.
  assign clamp_r = int_r >= ({1'b0, src_h} - IW'(1));
  assign clamp_c = int_c >= ({1'b0, src_w} - IW'(1));

  assign cfg_bad = (src_w < DIM_W'(2)) || (src_h < DIM_W'(2)) ||
                   (dst_w == '0) || (dst_h == '0);

  assign inv_r = ONE - dr;
  assign inv_c = ONE - dc;
  assign p3 = PW'(inv_r) * PW'(inv_c);
  assign p4 = PW'(dr)    * PW'(inv_c);
  assign p5 = PW'(inv_r) * PW'(dc);
  assign p6 = PW'(dr)    * PW'(dc);

  // NOTE: every register here is assigned with <= so all updates take effect together
  // at the clock edge, whatever order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc_r      <= '0;
      acc_c      <= '0;
      dr         <= '0;
      dc         <= '0;
      err_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      rd_req     <= 1'b0;
      rd_row     <= '0;
      rd_col     <= '0;
      m3         <= '0;
      m4         <= '0;
      m5         <= '0;
      m6         <= '0;
      calc_valid <= 1'b0;
      dst_row    <= '0;
      dst_col    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          cfg_err <= 1'b0;
          if (start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              acc_r   <= '0;
              acc_c   <= '0;
              dst_row <= '0;
              dst_col <= '0;
              busy    <= 1'b1;
              state   <= ADDR;
            end
          end
        end

        ADDR: begin
          rd_row <= clamp_r ? src_h - DIM_W'(2) : int_r[DIM_W-1:0];
          rd_col <= clamp_c ? src_w - DIM_W'(2) : int_c[DIM_W-1:0];
          dr     <= clamp_r ? ONE : {1'b0, acc_r[FRAC-1:0]};
          dc     <= clamp_c ? ONE : {1'b0, acc_c[FRAC-1:0]};
          rd_req <= 1'b1;
          state  <= FETCH;
        end

        FETCH: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= WEIGHT;
          end
        end

        WEIGHT: begin
          m3         <= WL'(p3 >> FRAC);
          m4         <= WL'(p4 >> FRAC);
          m5         <= WL'(p5 >> FRAC);
          m6         <= WL'(p6 >> FRAC);
          calc_valid <= 1'b1;
          state      <= EMIT;
        end

        EMIT: begin
          if (out_ready) begin
            calc_valid <= 1'b0;
            if (dst_col < dst_w - DIM_W'(1)) begin
              dst_col <= dst_col + DIM_W'(1);
              acc_c   <= acc_c + AW'(scale_c);
              state   <= ADDR;
            end else if (dst_row < dst_h - DIM_W'(1)) begin
              dst_col <= '0;
              acc_c   <= '0;
              dst_row <= dst_row + DIM_W'(1);
              acc_r   <= acc_r + AW'(scale_r);
              state   <= ADDR;
            end else begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end

        DONE: begin
          done    <= 1'b1;
          cfg_err <= err_q;
          err_q   <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rescale_scheduler.sv
// Self-checking bench for rescale_scheduler: directed frames from the test plan plus
// randomized frames and handshake delays checked against a behavioural pixel model.
module tb_rescale_scheduler;

  localparam int DIM_W = 10;
  localparam int FRAC  = 5;
  localparam int WL    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [DIM_W-1:0] src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
  logic [WL-1:0]    scale_c = '0, scale_r = '0;
  logic             rd_ack = 1'b0, out_ready = 1'b0;
  logic             busy, done, cfg_err, rd_req, calc_valid;
  logic [DIM_W-1:0] rd_row, rd_col, dst_row, dst_col;
  logic [WL-1:0]    m3, m4, m5, m6;

  rescale_scheduler #(.DIM_W(DIM_W), .FRAC(FRAC), .WL(WL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
    .scale_c(scale_c), .scale_r(scale_r),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_ack(rd_ack),
    .m3(m3), .m4(m4), .m5(m5), .m6(m6),
    .calc_valid(calc_valid), .out_ready(out_ready),
    .dst_row(dst_row), .dst_col(dst_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [108:0] outs_all = {busy, done, cfg_err, rd_req, calc_valid, rd_row, rd_col,
                           dst_row, dst_col, m3, m4, m5, m6};

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int row, col, rr, rc, m3, m4, m5, m6;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   acc_cyc[$];

  function automatic logic [159:0] pk(int rr, int rc, int a, int b, int c, int d);
    return {10'(rr), 10'(rc), 16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  // One axis of the neighbourhood: base index and delta in 1/32 units.
  function automatic void axis(input int acc, input int s, output int base, output int d);
    int ip;
    ip = acc / 32;
    if (ip >= s - 1) begin
      base = s - 2;
      d    = 32;
    end else begin
      base = ip;
      d    = acc % 32;
    end
  endfunction

  function automatic void model_push(int sw, int sh, int dw, int dh, int sr, int sc);
    pix_t p;
    int dr, dc;
    for (int r = 0; r < dh; r++) begin
      for (int c = 0; c < dw; c++) begin
        p.row = r;
        p.col = c;
        axis((r * sr) % 65536, sh, p.rr, dr);
        axis((c * sc) % 65536, sw, p.rc, dc);
        p.m3 = ((32 - dr) * (32 - dc)) / 32;
        p.m4 = (dr * (32 - dc)) / 32;
        p.m5 = ((32 - dr) * dc) / 32;
        p.m6 = (dr * dc) / 32;
        exp_q.push_back(p);
      end
    end
  endfunction

  // Handshake responder: per-transaction delay, optional forced stalls, idle-time noise.
  int ack_force = -1, ack_max = 0, rdy_max = 0;
  int bp_row = -1, bp_col = -1, bp_len = 0;
  bit idle_rand = 1'b0;
  int ack_cnt, ack_dly, rdy_cnt, rdy_dly;
  bit ack_on = 1'b0, rdy_on = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rd_req) begin
      if (!ack_on) begin
        ack_on  = 1'b1;
        ack_cnt = 0;
        ack_dly = (ack_force >= 0) ? ack_force : int'($urandom_range(0, ack_max));
      end
      rd_ack = (ack_cnt >= ack_dly);
      ack_cnt++;
    end else begin
      ack_on = 1'b0;
      rd_ack = idle_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (calc_valid) begin
      if (!rdy_on) begin
        rdy_on  = 1'b1;
        rdy_cnt = 0;
        rdy_dly = (int'(dst_row) == bp_row && int'(dst_col) == bp_col) ? bp_len
                : int'($urandom_range(0, rdy_max));
      end
      out_ready = (rdy_cnt >= rdy_dly);
      rdy_cnt++;
    end else begin
      rdy_on    = 1'b0;
      out_ready = idle_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: protocol rules every cycle, accepted pixels against the model.
  int n_acc, done_cnt, done_cyc, req_cnt, first_req_cyc, last_ack_cyc, req_len_cur, req_len_last;
  bit busy_seen, done_err;
  bit pv_wait = 1'b0, pr_wait = 1'b0, prev_valid = 1'b0, prev_done = 1'b0;
  logic [83:0] snap_v;
  logic [19:0] snap_r;
  pix_t mon_g, mon_e;

  always @(negedge clk) begin
    if (rst) begin
      pv_wait     = 1'b0;
      pr_wait     = 1'b0;
      prev_valid  = 1'b0;
      prev_done   = 1'b0;
      req_len_cur = 0;
    end else begin
      if (pv_wait) begin
        check("valid_hold", calc_valid, 1'b1);
        check("emit_stable", {m3, m4, m5, m6, dst_row, dst_col}, snap_v);
      end
      if (pr_wait) begin
        check("req_hold", rd_req, 1'b1);
        check("req_addr_stable", {rd_row, rd_col}, snap_r);
      end
      if (calc_valid) check("req_during_valid", rd_req, 1'b0);
      if (!done) check("cfg_err_only_with_done", cfg_err, 1'b0);
      if (busy) busy_seen = 1'b1;
      if (rd_req) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        req_len_cur++;
      end else if (req_len_cur != 0) begin
        req_len_last = req_len_cur;
        req_len_cur  = 0;
        req_cnt++;
      end
      if (rd_req && rd_ack) last_ack_cyc = cyc;
      if (calc_valid && !prev_valid) check("weight_after_ack", cyc - last_ack_cyc, 2);
      if (calc_valid && out_ready) begin
        mon_g = '{int'(dst_row), int'(dst_col), int'(rd_row), int'(rd_col),
                  int'(m3), int'(m4), int'(m5), int'(m6)};
        got_q.push_back(mon_g);
        acc_cyc.push_back(cyc);
        n_acc++;
        if (exp_q.size() == 0) begin
          check("extra_pixel", exp_q.size() != 0, 1'b1);
        end else begin
          mon_e = exp_q.pop_front();
          check("pix_pos", {dst_row, dst_col, rd_row, rd_col},
                {10'(mon_e.row), 10'(mon_e.col), 10'(mon_e.rr), 10'(mon_e.rc)});
          check("pix_weights", {m3, m4, m5, m6},
                {16'(mon_e.m3), 16'(mon_e.m4), 16'(mon_e.m5), 16'(mon_e.m6)});
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = cfg_err;
        check("done_single", prev_done, 1'b0);
        check("busy_at_done", busy, 1'b0);
      end
      pv_wait    = calc_valid && !out_ready;
      snap_v     = {m3, m4, m5, m6, dst_row, dst_col};
      pr_wait    = rd_req && !rd_ack;
      snap_r     = {rd_row, rd_col};
      prev_valid = calc_valid;
      prev_done  = done;
    end
  end

  task automatic clear_track();
    n_acc = 0; done_cnt = 0; done_cyc = -1; req_cnt = 0; first_req_cyc = -1;
    last_ack_cyc = -100; req_len_last = 0; busy_seen = 1'b0; done_err = 1'b0;
    got_q.delete();
    acc_cyc.delete();
  endtask

  task automatic set_cfg(int sw, int sh, int dw, int dh, int sr, int sc);
    src_w = DIM_W'(sw); src_h = DIM_W'(sh);
    dst_w = DIM_W'(dw); dst_h = DIM_W'(dh);
    scale_r = WL'(sr); scale_c = WL'(sc);
  endtask

  task automatic run_frame(int sw, int sh, int dw, int dh, int sr, int sc,
                           bit exp_err, int extra_at);
    int start_cyc;
    @(posedge clk); #1;
    clear_track();
    set_cfg(sw, sh, dw, dh, sr, sc);
    if (!exp_err) model_push(sw, sh, dw, dh, sr, sc);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      start = (i == extra_at);
    end
    start = 1'b0;
    check("frame_done_seen", done_cnt, 1);
    repeat (2) @(posedge clk);
    #1;
    check("cfg_err_flag", done_err, exp_err);
    check("pixel_count", n_acc, exp_err ? 0 : dw * dh);
    check("model_drained", exp_q.size(), 0);
    if (exp_err) begin
      check("err_done_latency", done_cyc - start_cyc, 2);
      check("err_no_req", {req_cnt, first_req_cyc}, {32'd0, -32'sd1});
      check("err_no_busy", busy_seen, 1'b0);
    end else begin
      check("start_to_req", first_req_cyc - start_cyc, 2);
      if (acc_cyc.size() > 0) check("done_after_accept", done_cyc - acc_cyc[acc_cyc.size()-1], 2);
    end
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int sw, sh, dw, dh;

    #3 rst = 1'b1;
    #1 check("reset_outputs", outs_all, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Upscale 2x2 -> 4x4 at 0.5 with handshakes tied high.
    run_frame(2, 2, 4, 4, 16, 16, 1'b0, -1);
    if (got_q.size() == 16) begin
      check("t1_pix00", pk(got_q[0].rr, got_q[0].rc, got_q[0].m3, got_q[0].m4, got_q[0].m5, got_q[0].m6),
            pk(0, 0, 32, 0, 0, 0));
      check("t1_pix01", pk(got_q[1].rr, got_q[1].rc, got_q[1].m3, got_q[1].m4, got_q[1].m5, got_q[1].m6),
            pk(0, 0, 16, 0, 16, 0));
      check("t1_pix03_clamp", pk(got_q[3].rr, got_q[3].rc, got_q[3].m3, got_q[3].m4, got_q[3].m5, got_q[3].m6),
            pk(0, 0, 0, 0, 32, 0));
      check("t1_pix11", pk(got_q[5].rr, got_q[5].rc, got_q[5].m3, got_q[5].m4, got_q[5].m5, got_q[5].m6),
            pk(0, 0, 8, 8, 8, 8));
      check("t1_pix33_clamp", pk(got_q[15].rr, got_q[15].rc, got_q[15].m3, got_q[15].m4, got_q[15].m5, got_q[15].m6),
            pk(0, 0, 0, 0, 0, 32));
      for (int k = 1; k < 16; k++) check("t1_spacing", acc_cyc[k] - acc_cyc[k-1], 4);
    end

    // Backpressure: out_ready held low 5 cycles on pixel (1,2).
    bp_row = 1; bp_col = 2; bp_len = 5;
    run_frame(2, 2, 4, 4, 16, 16, 1'b0, -1);
    if (acc_cyc.size() == 16) check("bp_stall_spacing", acc_cyc[6] - acc_cyc[5], 9);
    bp_row = -1; bp_col = -1;

    // rd_ack delayed 3 cycles on every fetch.
    ack_force = 3;
    run_frame(2, 2, 4, 4, 16, 16, 1'b0, -1);
    check("ack_req_len", req_len_last, 4);
    if (acc_cyc.size() == 16) check("ack_spacing", acc_cyc[1] - acc_cyc[0], 7);
    ack_force = -1;

    // Illegal configurations and the smallest legal one.
    run_frame(1, 4, 3, 3, 16, 16, 1'b1, -1);
    run_frame(4, 1, 3, 3, 16, 16, 1'b1, -1);
    run_frame(4, 4, 0, 3, 16, 16, 1'b1, -1);
    run_frame(4, 4, 3, 0, 16, 16, 1'b1, -1);
    run_frame(2, 2, 1, 1, 0, 0, 1'b0, -1);

    // Reset during EMIT of pixel (2,0), then a clean restart with a stray start while busy.
    @(posedge clk); #1;
    clear_track();
    set_cfg(2, 2, 4, 4, 16, 16);
    model_push(2, 2, 4, 4, 16, 16);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (calc_valid && dst_row == 2 && dst_col == 0) found = 1'b1;
    end
    check("rst_reached_emit", found, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_mid_outputs", outs_all, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 check("rst_no_done", done_cnt, 0);
    run_frame(2, 2, 4, 4, 16, 16, 1'b0, 5);

    // Randomized frames with random handshake delays and idle-time noise.
    idle_rand = 1'b1; ack_max = 3; rdy_max = 3;
    for (int f = 0; f < 8; f++) begin
      sw = $urandom_range(2, 12);
      sh = $urandom_range(2, 12);
      dw = $urandom_range(1, 6);
      dh = $urandom_range(1, 6);
      run_frame(sw, sh, dw, dh, $urandom_range(0, 80), $urandom_range(0, 80), 1'b0,
                (dw * dh >= 4) ? 3 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rescale_scheduler.md
Name: rescale_scheduler

Overview:
- Frame-level sequencer for the bilinear rescale datapath. Walks every destination pixel in raster order and derives the 2x2 source neighbourhood base address.
- Fetches that neighbourhood through a request/ack port, then computes the four Q5 weights m3..m6 for the pixel calculator.
- Presents one weight set per pixel under a valid/ready handshake. Sits between the register/config interface and the per-colour pixel calculator instances.

Parameters:
- DIM_W, 10, width of row/column coordinates and dimensions.
- FRAC, 5, fractional bits of the fixed-point format.
- WL, 16, word length of fixed-point scale inputs and weight outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- src_w, src_h  in  DIM_W  source dimensions
- dst_w, dst_h  in  DIM_W  destination dimensions
- scale_c, scale_r  in  WL  per-step source increment, Q(WL-FRAC).FRAC; stable while busy
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  set with done when configuration is illegal
- rd_req  out  1  neighbourhood fetch request
- rd_row, rd_col  out  DIM_W  top-left neighbour (n0) coordinate
- rd_ack  in  1  fetch complete; n0..n3 valid downstream
- m3, m4, m5, m6  out  WL  Q5 weights
- calc_valid  out  1  weights and dst coordinates valid
- out_ready  in  1  downstream accepts
- dst_row, dst_col  out  DIM_W  destination coordinate of the current pixel

Behaviour:
- Reset: asynchronous and active-high. Clock is clk; reset is rst. Reset forces IDLE immediately and zeroes every output, accumulator and counter. Reset mid-frame abandons the frame with no done pulse.
- FSM states: IDLE, ADDR, FETCH, WEIGHT, EMIT, DONE.
- IDLE:
  - When start=1, check the configuration. It is illegal if src_w<2, src_h<2, dst_w=0 or dst_h=0. If illegal, go to DONE with cfg_err=1.
  - Otherwise clear acc_r, acc_c, dst_row and dst_col; set busy=1; go to ADDR.
- While busy, start is ignored.
- Accumulators: acc_r and acc_c are each DIM_W+FRAC+1 bits, unsigned. int = acc>>FRAC and frac = acc[FRAC-1:0].
- ADDR (1 cycle), per axis (columns shown; rows identical with src_h):
  - If int_c >= src_w-1: rd_col=src_w-2 and delta_c=32, an exact 1.0 edge clamp.
  - Otherwise rd_col=int_c and delta_c=frac_c.
  - Deltas are 6 bits, range 0..32. Next state is FETCH.
- FETCH:
  - rd_req=1 with rd_row/rd_col held. Neighbour order: n0=(r,c), n1=(r+1,c), n2=(r,c+1), n3=(r+1,c+1).
  - The transfer completes on the first edge where rd_req and rd_ack are both 1; ack in the cycle rd_req rises is legal.
  - rd_req drops the next cycle; next state is WEIGHT. rd_ack outside FETCH is ignored.
- WEIGHT (1 cycle), with products truncated (>>5), each weight 0..32 and zero-extended to WL:
  - m3=((32-dr)*(32-dc))>>5
  - m4=(dr*(32-dc))>>5
  - m5=((32-dr)*dc)>>5
  - m6=(dr*dc)>>5
  - The sum of the four weights may be below 32 through truncation; this is accepted.
- EMIT:
  - calc_valid=1. m3..m6, dst_row and dst_col stay stable until out_ready=1, then calc_valid drops.
  - On accept, if dst_col<dst_w-1: dst_col++, acc_c+=scale_c, go to ADDR.
  - Else if dst_row<dst_h-1: dst_col=0, acc_c=0, dst_row++, acc_r+=scale_r, go to ADDR.
  - Else go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, cfg_err held with done only; then IDLE.
- Throughput: 4 cycles per pixel minimum with same-cycle rd_ack and out_ready.
- Latency: start edge to rd_req=1 is 2 cycles.
- Accumulator overflow is a software error and is not checked. Integer clamping bounds the addresses regardless.

Test Plan:
- Upscale 2x2->4x4, scale_r=scale_c=16 (0.5), rd_ack and out_ready tied 1 -> exactly 16 calc_valid pulses in raster order. Pixel (0,0) gives rd=(0,0), m3=32, m4=m5=m6=0. Pixel (0,1) gives m3=16, m5=16. Pixel (1,1) gives m3=m4=m5=m6=8. done one cycle after the last accept; pixel-to-pixel spacing is 4 cycles.
- Edge clamp, same frame, pixel (0,3): acc_c=48 (int 1 = src_w-1) -> rd_col=0, dc=32, m3=0, m5=32. Pixel (3,3) gives rd=(0,0) and m6=32.
- Backpressure: out_ready low 5 cycles on pixel (1,2) -> calc_valid, weights and dst coords stable for 5 cycles. No new rd_req until accept.
- rd_ack delayed 3 cycles -> rd_req held 4 cycles with constant rd_row/rd_col. WEIGHT follows the cycle after ack.
- Config error: start with src_w=1 -> no rd_req; done=1 and cfg_err=1 together 2 cycles after start; busy never 1.
- Reset mid-frame: assert rst during EMIT of pixel (2,0) -> all outputs 0 immediately and no done. A subsequent start restarts at pixel (0,0). A start pulse while busy changes nothing.
